// File: rtl/ip_rewrite_flow_table.sv
// rtl/ip_rewrite_flow_table.sv - flow-key lookup table returning an IP rewrite address
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   lookup_rd_table_val/key/rdy   lookup request handshake
//   table_lookup_resp_val/hit/addr lookup response (addr is 0 on miss)
//   lookup_table_resp_rdy         response consumed
//   wr_table_val/index/clear/key/addr/rdy  entry install/invalidate handshake
//   table_hit_cnt, table_miss_cnt saturating lookup statistics
module ip_rewrite_flow_table #(
    parameter int NUM_ENTRIES = 8,
    parameter int KEY_W       = 96,
    parameter int ADDR_W      = 32,
    localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_rd_table_val,
    input  logic [KEY_W-1:0]  lookup_rd_table_key,
    output logic              lookup_rd_table_rdy,
    output logic              table_lookup_resp_val,
    output logic              table_lookup_resp_hit,
    output logic [ADDR_W-1:0] table_lookup_resp_addr,
    input  logic              lookup_table_resp_rdy,
    input  logic              wr_table_val,
    input  logic [IDX_W-1:0]  wr_table_index,
    input  logic              wr_table_clear,
    input  logic [KEY_W-1:0]  wr_table_key,
    input  logic [ADDR_W-1:0] wr_table_addr,
    output logic              wr_table_rdy,
    output logic [31:0]       table_hit_cnt,
    output logic [31:0]       table_miss_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    logic [1:0]             state;
    logic [NUM_ENTRIES-1:0] entry_valid;
    logic [KEY_W-1:0]       entry_key  [NUM_ENTRIES];
    logic [ADDR_W-1:0]      entry_addr [NUM_ENTRIES];
    logic [KEY_W-1:0]       key_q;
    logic                   resp_hit_q;
    logic [ADDR_W-1:0]      resp_addr_q;
    logic [31:0]            hit_cnt_q;
    logic [31:0]            miss_cnt_q;
    logic                   match_hit;
    logic [ADDR_W-1:0]      match_addr;
    logic                   lookup_fire;
    logic                   wr_fire;

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign lookup_rd_table_rdy    = rst_n && (state == ST_IDLE);
    assign wr_table_rdy           = rst_n && ((state == ST_IDLE) || (state == ST_RESP));
    assign table_lookup_resp_val  = (state == ST_RESP);
    assign table_lookup_resp_hit  = resp_hit_q;
    assign table_lookup_resp_addr = resp_addr_q;
    assign table_hit_cnt          = hit_cnt_q;
    assign table_miss_cnt         = miss_cnt_q;
    assign lookup_fire            = lookup_rd_table_val && lookup_rd_table_rdy;
    assign wr_fire                = wr_table_val && wr_table_rdy;

    // Scan from the top down so the lowest matching index is the last to win.
    always_comb begin
        match_hit  = 1'b0;
        match_addr = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (entry_valid[i] && (entry_key[i] == key_q)) begin
                match_hit  = 1'b1;
                match_addr = entry_addr[i];
            end
        end
    end

    // Key/address payload needs no reset: valid bits alone gate matching.
    always_ff @(posedge clk) begin
        if (wr_fire && !wr_table_clear) begin
            entry_key[wr_table_index]  <= wr_table_key;
            entry_addr[wr_table_index] <= wr_table_addr;
        end
        if (lookup_fire) begin
            key_q <= lookup_rd_table_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_valid <= '0;
        end else if (wr_fire) begin
            entry_valid[wr_table_index] <= !wr_table_clear;
        end
    end

    // The compare happens the cycle after acceptance, so a write accepted
    // alongside the lookup is already in the table when it is searched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            resp_hit_q  <= 1'b0;
            resp_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lookup_fire) begin
                        state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    resp_hit_q  <= match_hit;
                    resp_addr_q <= match_addr;
                    if (match_hit) begin
                        if (hit_cnt_q != 32'hFFFF_FFFF) begin
                            hit_cnt_q <= hit_cnt_q + 32'd1;
                        end
                    end else begin
                        if (miss_cnt_q != 32'hFFFF_FFFF) begin
                            miss_cnt_q <= miss_cnt_q + 32'd1;
                        end
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (lookup_table_resp_rdy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_rewrite_flow_table.sv
// tb/tb_ip_rewrite_flow_table.sv - scoreboard bench for ip_rewrite_flow_table
module tb_ip_rewrite_flow_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lookup_val = 1'b0;
    logic [95:0] lookup_key = '0;
    logic        lookup_rdy;
    logic        resp_val;
    logic        resp_hit;
    logic [31:0] resp_addr;
    logic        resp_rdy = 1'b0;
    logic        wr_val = 1'b0;
    logic [2:0]  wr_index = '0;
    logic        wr_clear = 1'b0;
    logic [95:0] wr_key = '0;
    logic [31:0] wr_addr = '0;
    logic        wr_rdy;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    typedef struct packed {
        logic        hit;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_hits = '0;
    logic [31:0] exp_misses = '0;

    localparam logic [95:0] K1 = {32'hC0A8_0001, 32'h0A00_0001, 16'd1234, 16'd80};
    localparam logic [95:0] K2 = {32'hC0A8_0002, 32'h0A00_0002, 16'd4000, 16'd443};
    localparam logic [95:0] K3 = {32'hAC10_0003, 32'h0A00_0003, 16'd5555, 16'd53};
    localparam logic [95:0] K4 = {32'hAC10_0004, 32'h0A00_0004, 16'd6666, 16'd22};
    localparam logic [95:0] K9 = {32'hDEAD_BEEF, 32'h0102_0304, 16'd9, 16'd9};
    localparam logic [31:0] ADDR_K1 = 32'h0A00_0005;
    localparam logic [31:0] ADDR_A  = 32'h0B00_0001;
    localparam logic [31:0] ADDR_B  = 32'h0B00_0006;
    localparam logic [31:0] ADDR_C  = 32'h0C00_0033;
    localparam logic [31:0] ADDR_D  = 32'h0D00_0055;
    localparam logic [31:0] ADDR_E  = 32'h0E00_0077;

    ip_rewrite_flow_table dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .lookup_rd_table_val    (lookup_val),
        .lookup_rd_table_key    (lookup_key),
        .lookup_rd_table_rdy    (lookup_rdy),
        .table_lookup_resp_val  (resp_val),
        .table_lookup_resp_hit  (resp_hit),
        .table_lookup_resp_addr (resp_addr),
        .lookup_table_resp_rdy  (resp_rdy),
        .wr_table_val           (wr_val),
        .wr_table_index         (wr_index),
        .wr_table_clear         (wr_clear),
        .wr_table_key           (wr_key),
        .wr_table_addr          (wr_addr),
        .wr_table_rdy           (wr_rdy),
        .table_hit_cnt          (hit_cnt),
        .table_miss_cnt         (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where RESP should be shown.
    task automatic start_lookup(input logic [95:0] key, input logic hit, input logic [31:0] addr);
        lookup_val = 1'b1;
        lookup_key = key;
        chk("lookup_rdy_idle", {31'd0, lookup_rdy}, 32'd1);
        @(negedge clk);
        lookup_val = 1'b0;
        sb.push_back('{hit: hit, addr: (hit ? addr : 32'd0)});
        chk("resp_val_in_compare", {31'd0, resp_val}, 32'd0);
        chk("lookup_rdy_compare", {31'd0, lookup_rdy}, 32'd0);
        @(negedge clk);
        chk("resp_val_latency", {31'd0, resp_val}, 32'd1);
    endtask

    task automatic finish_resp();
        exp_t e;
        for (int i = 0; i < 20 && !resp_val; i++) @(negedge clk);
        chk("resp_val_timeout", {31'd0, resp_val}, 32'd1);
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        if (e.hit) exp_hits = (exp_hits == 32'hFFFF_FFFF) ? exp_hits : exp_hits + 32'd1;
        else       exp_misses = (exp_misses == 32'hFFFF_FFFF) ? exp_misses : exp_misses + 32'd1;
        chk("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
        chk("resp_addr", resp_addr, e.addr);
        chk("hit_cnt", hit_cnt, exp_hits);
        chk("miss_cnt", miss_cnt, exp_misses);
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        chk("resp_val_after_consume", {31'd0, resp_val}, 32'd0);
    endtask

    task automatic lookup(input logic [95:0] key, input logic hit, input logic [31:0] addr);
        start_lookup(key, hit, addr);
        finish_resp();
    endtask

    task automatic write(input logic [2:0] idx, input logic clr, input logic [95:0] key,
                         input logic [31:0] addr);
        wr_val   = 1'b1;
        wr_index = idx;
        wr_clear = clr;
        wr_key   = key;
        wr_addr  = addr;
        for (int i = 0; i < 20 && !wr_rdy; i++) @(negedge clk);
        chk("wr_rdy", {31'd0, wr_rdy}, 32'd1);
        @(negedge clk);
        wr_val = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_lookup_rdy", {31'd0, lookup_rdy}, 32'd0);
        chk("rst_wr_rdy", {31'd0, wr_rdy}, 32'd0);
        chk("rst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_lookup_rdy", {31'd0, lookup_rdy}, 32'd1);
        chk("post_rst_wr_rdy", {31'd0, wr_rdy}, 32'd1);

        // Miss on empty table, then install/hit, clear/miss
        lookup(K9, 1'b0, 32'd0);
        write(3'd3, 1'b0, K1, ADDR_K1);
        lookup(K1, 1'b1, ADDR_K1);
        write(3'd3, 1'b1, '0, '0);
        lookup(K1, 1'b0, 32'd0);

        // Duplicate key: lowest index wins regardless of install order
        write(3'd6, 1'b0, K2, ADDR_B);
        write(3'd1, 1'b0, K2, ADDR_A);
        lookup(K2, 1'b1, ADDR_A);

        // Back-pressure: response held, new request blocked, write accepted
        start_lookup(K2, 1'b1, ADDR_A);
        wr_val = 1'b1; wr_index = 3'd3; wr_clear = 1'b0; wr_key = K1; wr_addr = ADDR_C;
        lookup_val = 1'b1; lookup_key = K1;
        for (int i = 0; i < 10; i++) begin
            chk("hold_resp_val", {31'd0, resp_val}, 32'd1);
            chk("hold_resp_hit", {31'd0, resp_hit}, 32'd1);
            chk("hold_resp_addr", resp_addr, ADDR_A);
            chk("hold_lookup_rdy", {31'd0, lookup_rdy}, 32'd0);
            if (i == 0) chk("hold_wr_rdy", {31'd0, wr_rdy}, 32'd1);
            @(negedge clk);
            if (i == 0) wr_val = 1'b0;
        end
        lookup_val = 1'b0;
        finish_resp();
        lookup(K1, 1'b1, ADDR_C);

        // Same-cycle install + lookup, then write offered during COMPARE
        wr_val = 1'b1; wr_index = 3'd5; wr_clear = 1'b0; wr_key = K3; wr_addr = ADDR_D;
        lookup_val = 1'b1; lookup_key = K3;
        chk("same_cycle_lookup_rdy", {31'd0, lookup_rdy}, 32'd1);
        chk("same_cycle_wr_rdy", {31'd0, wr_rdy}, 32'd1);
        @(negedge clk);
        lookup_val = 1'b0;
        sb.push_back('{hit: 1'b1, addr: ADDR_D});
        wr_index = 3'd7; wr_key = K4; wr_addr = ADDR_E;
        chk("compare_wr_rdy", {31'd0, wr_rdy}, 32'd0);
        @(negedge clk);
        chk("resp_wr_rdy", {31'd0, wr_rdy}, 32'd1);
        chk("resp_val_same_cycle", {31'd0, resp_val}, 32'd1);
        @(negedge clk);
        wr_val = 1'b0;
        finish_resp();
        lookup(K4, 1'b1, ADDR_E);

        // Miss counter saturation
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.miss_cnt_q;
        exp_misses = 32'hFFFF_FFFE;
        chk("miss_cnt_preload", miss_cnt, 32'hFFFF_FFFE);
        lookup(K9, 1'b0, 32'd0);
        lookup(K9, 1'b0, 32'd0);

        // Reset while a response is pending
        start_lookup(K2, 1'b1, ADDR_A);
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("midrst_resp_hit", {31'd0, resp_hit}, 32'd0);
        chk("midrst_resp_addr", resp_addr, 32'd0);
        chk("midrst_lookup_rdy", {31'd0, lookup_rdy}, 32'd0);
        chk("midrst_wr_rdy", {31'd0, wr_rdy}, 32'd0);
        chk("midrst_hit_cnt", hit_cnt, 32'd0);
        chk("midrst_miss_cnt", miss_cnt, 32'd0);
        sb.delete();
        exp_hits = '0;
        exp_misses = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", {31'd0, resp_val}, 32'd0);
        end
        lookup(K2, 1'b0, 32'd0);
        lookup(K4, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
